hazard_ctrl: RTL and testbench

//  Pipeline stall/flush controller for the 5-stage CPU: the producer side of the hazard

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-protocol bundle between the pipeline datapath (master) and the stall/flush
// controller (slave): ID/EX/MEM hazard inputs and per-stage enable/clear controls.
interface hazard_ctrl_if;
   logic [4:0] rs0_id;
   logic [4:0] rs1_id;
   logic [4:0] rd_ex;
   logic       regwrite_ex;
   logic       memread_ex;
   logic       br_taken_ex;
   logic       dmem_req;
   logic       dmem_ready;

   logic       pc_en;
   logic       pc_redirect;
   logic       ifid_en;
   logic       ifid_clr;
   logic       idex_en;
   logic       idex_clr;
   logic       exmem_en;
   logic       memwb_clr;
   logic       mem_err;

   modport master (
      output rs0_id, rs1_id, rd_ex, regwrite_ex, memread_ex, br_taken_ex,
             dmem_req, dmem_ready,
      input  pc_en, pc_redirect, ifid_en, ifid_clr, idex_en, idex_clr,
             exmem_en, memwb_clr, mem_err
   );

   modport slave (
      input  rs0_id, rs1_id, rd_ex, regwrite_ex, memread_ex, br_taken_ex,
             dmem_req, dmem_ready,
      output pc_en, pc_redirect, ifid_en, ifid_clr, idex_en, idex_clr,
             exmem_en, memwb_clr, mem_err
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubble, taken-branch squash and bounded
// data-memory wait. Define HAZARD_PERF_EN to add stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]  stall_cnt,
   output logic [31:0]  flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             memstall;
   logic             loaduse;

   // Once in ERR the pending access is dropped so the pipeline can drain.
   assign memstall = hz.dmem_req & ~hz.dmem_ready & (state_q != ERR);
   assign loaduse  = hz.memread_ex & hz.regwrite_ex & (hz.rd_ex != 5'd0) &
                     ((hz.rd_ex == hz.rs0_id) | (hz.rd_ex == hz.rs1_id));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         RUN: begin
            if (memstall) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = ONE_C;
            end
         end
         MEM_WAIT: begin
            if (!memstall) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q >= TIMEOUT_C) begin
               state_d   = ERR;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + ONE_C;
            end
         end
         ERR: begin
            mem_err_d = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // A taken branch held behind a memory stall is serviced the cycle the stall releases.
   always_comb begin
      hz.pc_en       = 1'b1;
      hz.pc_redirect = 1'b0;
      hz.ifid_en     = 1'b1;
      hz.ifid_clr    = 1'b0;
      hz.idex_en     = 1'b1;
      hz.idex_clr    = 1'b0;
      hz.exmem_en    = 1'b1;
      hz.memwb_clr   = 1'b0;
      if (memstall) begin
         hz.pc_en     = 1'b0;
         hz.ifid_en   = 1'b0;
         hz.idex_en   = 1'b0;
         hz.exmem_en  = 1'b0;
         hz.memwb_clr = 1'b1;
      end else if (hz.br_taken_ex) begin
         hz.pc_redirect = 1'b1;
         hz.ifid_clr    = 1'b1;
         hz.idex_clr    = 1'b1;
      end else if (loaduse) begin
         hz.pc_en    = 1'b0;
         hz.ifid_en  = 1'b0;
         hz.idex_clr = 1'b1;
      end
   end

   assign hz.mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!hz.pc_en) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (hz.pc_redirect) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: load-use, branch squash, memory wait and timeout.
// Output vector order: pc_en,pc_redirect,ifid_en,ifid_clr,idex_en,idex_clr,exmem_en,memwb_clr,mem_err.
module tb_hazard_ctrl;

   localparam logic [8:0] NORM = 9'b1_0_1_0_1_0_1_0_0;
   localparam logic [8:0] LU   = 9'b0_0_0_0_1_1_1_0_0;
   localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_1_0_0;
   localparam logic [8:0] MS   = 9'b0_0_0_0_0_0_0_1_0;
   localparam logic [8:0] ERRB = 9'b0_0_0_0_0_0_0_0_1;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .hz        (hif.slave)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [8:0] outVec();
      return {hif.pc_en, hif.pc_redirect, hif.ifid_en, hif.ifid_clr, hif.idex_en,
              hif.idex_clr, hif.exmem_en, hif.memwb_clr, hif.mem_err};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic br,
                                input logic req, input logic rdy);
      hif.rs0_id      = rs0;
      hif.rs1_id      = rs1;
      hif.rd_ex       = rd;
      hif.regwrite_ex = rw;
      hif.memread_ex  = mr;
      hif.br_taken_ex = br;
      hif.dmem_req    = req;
      hif.dmem_ready  = rdy;
   endtask

   // Let the combinational outputs settle mid-cycle, compare, then step one clock.
   task automatic stepCheck(input string tag, input logic [8:0] exp);
      #2;
      checkOutput(tag, 32'(outVec()), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("reset_outputs", 32'(outVec()), 32'(NORM));
`ifdef HAZARD_PERF_EN
      checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
      checkOutput("reset_flush_cnt", flush_cnt, 32'd0);
`endif
      #10;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then the bubble's rd=x0 clears it
      applyStimulus(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCheck("lu_rs0", LU);
      applyStimulus(5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck("lu_bubble", NORM);
      applyStimulus(5'd2, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCheck("lu_rs1", LU);
      applyStimulus(5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCheck("lw_x0_exempt", NORM);
      applyStimulus(5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCheck("load_no_regwrite", NORM);
      applyStimulus(5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck("alu_forwarded", NORM);
      applyStimulus(5'd4, 5'd8, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCheck("load_no_match", NORM);
      applyStimulus(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      stepCheck("branch_over_lu", BR);
`ifdef HAZARD_PERF_EN
      checkOutput("perf_stall_cnt", stall_cnt, 32'd2);
      checkOutput("perf_flush_cnt", flush_cnt, 32'd1);
`endif
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      stepCheck("branch_alone", BR);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck("after_branch", NORM);

      // 3-cycle memory wait with a taken branch held in EX and a load-use pending
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         stepCheck($sformatf("memwait_%0d", i), MS);
      end
      applyStimulus(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      stepCheck("memwait_release_br", BR);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck("memwait_idle", NORM);

      // Release by dropping the request, then a fresh 16-cycle wait must not time out
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      stepCheck("req_drop_stall", MS);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck("req_drop_release", NORM);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         stepCheck($sformatf("wait16_%0d", i), MS);
      end
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      stepCheck("wait16_ready", NORM);

      // Reset mid-wait returns to reset values and restarts the wait count
      for (int i = 0; i < 10; i++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         stepCheck($sformatf("prerst_%0d", i), MS);
      end
      rst = 1'b1;
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("midwait_reset", 32'(outVec()), 32'(NORM));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 17 unready cycles: stalls through cycle 17, then ERR drains the pipeline
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         stepCheck($sformatf("tmo_cycle_%0d", i), MS);
      end
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      stepCheck("err_drain", NORM | ERRB);
      applyStimulus(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      stepCheck("err_loaduse", LU | ERRB);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      stepCheck("err_branch", BR | ERRB);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck("err_sticky", NORM | ERRB);

      rst = 1'b1;
      #2;
      checkOutput("err_cleared_by_rst", 32'(outVec()), 32'(NORM));
`ifdef HAZARD_PERF_EN
      checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
      checkOutput("rst_flush_cnt", flush_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck("post_rst_idle", NORM);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
